i2c_reg_bridge: RTL and testbench
=================================

Name: i2c_reg_bridge

Overview:
I2C target front-end that decodes I2C transactions from the host MCU and acts as initiator on the 8-bit register bus (reg_addr/reg_wdata/reg_wr/reg_rd/reg_rdata) consumed by register_file. It handles START/STOP detection, device-address match, the register-pointer byte, auto-incrementing burst writes and reads, and ACK/NACK generation. It sits between the top-level SCL/SDA pads and the register file.

Parameters:
SLAVE_ADDR, 7'h42, 7-bit I2C device address
SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (min 2)

Ports:
clk  input  1  system clock; must be >= 16x SCL frequency
rst  input  1  asynchronous, active-high reset
scl_in  input  1  SCL pad input (asynchronous)
sda_in  input  1  SDA pad input (asynchronous)
sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release
reg_addr  output  8  register pointer presented to register file
reg_wdata  output  8  write data
reg_wr  output  1  one-clk write strobe
reg_rd  output  1  one-clk read strobe; reg_rdata sampled in same cycle
reg_rdata  input  8  combinational read data for reg_addr
busy  output  1  high from addressed START until STOP

Behaviour:
- Reset values: sda_oe=0, reg_addr=0x00, reg_wdata=0x00, reg_wr=0, reg_rd=0, busy=0, state=IDLE. Reset mid-transfer releases SDA immediately (async) and discards the partial byte.
- scl_in/sda_in pass through SYNC_STAGES flops; edges are detected on the synchronized values. START = sda fall while scl high; STOP = sda rise while scl high. Both are recognised in every state, including repeated START.
- Bits are sampled on SCL rise, MSB first. sda_oe changes only in the clk cycle after an SCL fall.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_MACK, IGNORE.
- IDLE -> DEV_ADDR on START.
- DEV_ADDR: shift 8 bits. Match {SLAVE_ADDR,rw} -> DEV_ACK, busy=1. Mismatch -> IGNORE, with no ACK and no strobes.
- DEV_ACK: sda_oe=1 from the SCL fall after bit 8 until the SCL fall after bit 9. Then rw=0 -> REG_PTR; rw=1 -> RD_DATA.
- REG_PTR: the byte loads reg_addr on the 8th SCL rise. Go to PTR_ACK (ACK), then WR_DATA.
- WR_DATA: on the 8th SCL rise, reg_wdata<=byte and reg_wr pulses for exactly 1 clk with reg_addr unchanged. reg_addr then increments in the next clk (8-bit wrap 0xFF->0x00). Go to WR_ACK (ACK), then WR_DATA.
- RD_DATA entry (the SCL fall ending an ACK slot): in one clk, tx_shift<=reg_rdata and reg_rd pulses. In the next clk, reg_addr increments (wrap) and sda_oe=~tx_shift[7]. Each following SCL fall shifts out the next bit. After the 8th bit SDA is released and the state goes to RD_MACK.
- RD_MACK: sample SDA on the 9th SCL rise. 0 (ACK) -> RD_DATA at the next SCL fall. 1 (NACK) -> IGNORE.
- IGNORE: sda_oe=0. Leave only on START (-> DEV_ADDR) or STOP (-> IDLE).
- STOP in any state -> IDLE, busy=0, sda_oe=0. START in any state -> DEV_ADDR. A partial byte is dropped and issues no reg_wr.
- reg_addr persists across transactions and across START/STOP. This allows a pointer write, repeated START, and then a read from that pointer. Only reset clears it.
- reg_wr and reg_rd are never asserted in the same clk. Neither is asserted outside an addressed transaction.

Test Plan:
- START,0x84,0x20,0x5A,STOP -> ACK on all 3 bytes; exactly one reg_wr with reg_addr=0x20, reg_wdata=0x5A; reg_addr=0x21 afterwards; busy low after STOP.
- START,0x84,0x05,0x11,0x22,STOP -> reg_wr 0x11@0x05, then 0x22@0x06; final reg_addr=0x07.
- START,0x84,0x00,Sr,0x85, master reads 2 bytes (ACK then NACK), STOP -> SDA carries 0xA7 then 0x01; reg_rd pulses twice at reg_addr 0x00 then 0x01; SDA released after NACK.
- START,0x90,0x20,0x5A,STOP -> sda_oe=0 for the whole transfer; no reg_wr/reg_rd; busy=0.
- Pointer 0xFF, write 0x33,0x44 -> reg_wr 0x33@0xFF, then 0x44@0x00 (wrap).
- START,0x84,0x20, 4 data bits, STOP -> no reg_wr, state IDLE. Separately, rst asserted mid-RD_DATA -> sda_oe=0 within the same clk edge-free interval; all outputs at their reset values.

Source files
------------

// File: rtl/i2c_reg_bridge_if.sv
// Register-bus interface between the I2C bridge and the register file.
//   reg_addr  : register pointer (bridge -> register file)
//   reg_wdata : write data (bridge -> register file)
//   reg_wr    : one-clk write strobe (bridge -> register file)
//   reg_rd    : one-clk read strobe (bridge -> register file)
//   reg_rdata : combinational read data for reg_addr (register file -> bridge)
interface i2c_reg_bridge_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;

  modport master (output reg_addr, reg_wdata, reg_wr, reg_rd, input reg_rdata);
  modport slave  (input reg_addr, reg_wdata, reg_wr, reg_rd, output reg_rdata);
endinterface

// File: rtl/i2c_reg_bridge.sv
// I2C target front-end driving an 8-bit register bus.
// Decodes START/STOP, device address, register pointer, auto-incrementing
// burst writes/reads and generates ACKs.
//   clk     : system clock (>= 16x SCL)
//   rst     : asynchronous active-high reset
//   scl_in  : SCL pad input (asynchronous)
//   sda_in  : SDA pad input (asynchronous)
//   sda_oe  : 1 = pull SDA low (open drain)
//   busy    : high from an addressed START until STOP
//   rbus    : register bus (initiator side)
//
// state    | meaning
// IDLE     | bus free, waiting for START
// DEV_ADDR | shifting in device address + rw
// DEV_ACK  | acknowledging our device address
// REG_PTR  | shifting in register pointer
// PTR_ACK  | acknowledging pointer byte
// WR_DATA  | shifting in a write data byte
// WR_ACK   | acknowledging a write data byte
// RD_DATA  | fetching and shifting out a read byte
// RD_MACK  | sampling controller ACK/NACK after a read byte
// IGNORE   | not addressed / read ended, wait for START or STOP
module i2c_reg_bridge #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              busy,
  i2c_reg_bridge_if.master  rbus
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_PTR, PTR_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_MACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start_det, stop_det;

  state_t     state, state_nxt;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] rx_shift, rx_nxt, rx_byte;
  logic [7:0] tx_shift, tx_nxt;
  logic [1:0] rd_phase, rd_phase_nxt;
  logic       rw, rw_nxt;
  logic       sda_oe_nxt, busy_nxt;
  logic [7:0] addr_q, addr_nxt, wdata_q, wdata_nxt;
  logic       wr_q, wr_nxt, rd_q, rd_nxt;

  // Bus idles high, so synchronizers reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      rd_phase <= '0;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt_nxt;
      rx_shift <= rx_nxt;
      tx_shift <= tx_nxt;
      rd_phase <= rd_phase_nxt;
      rw       <= rw_nxt;
      sda_oe   <= sda_oe_nxt;
      busy     <= busy_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      wr_q     <= wr_nxt;
      rd_q     <= rd_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    rx_nxt       = rx_shift;
    tx_nxt       = tx_shift;
    rd_phase_nxt = rd_phase;
    rw_nxt       = rw;
    sda_oe_nxt   = sda_oe;
    busy_nxt     = busy;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;
    wr_nxt       = 1'b0;
    rd_nxt       = 1'b0;
    rx_byte      = {rx_shift[6:0], sda_s};

    // Pointer advances the clk after each write strobe.
    if (wr_q) addr_nxt = addr_q + 8'd1;

    if (stop_det) begin
      state_nxt   = IDLE;
      busy_nxt    = 1'b0;
      sda_oe_nxt  = 1'b0;
      bit_cnt_nxt = '0;
    end else if (start_det) begin
      state_nxt   = DEV_ADDR;
      sda_oe_nxt  = 1'b0;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        DEV_ADDR, REG_PTR, WR_DATA: begin
          if (scl_rise) begin
            rx_nxt      = rx_byte;
            bit_cnt_nxt = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt_nxt = '0;
              if (state == DEV_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  rw_nxt    = rx_byte[0];
                  busy_nxt  = 1'b1;
                  state_nxt = DEV_ACK;
                end else begin
                  busy_nxt  = 1'b0;
                  state_nxt = IGNORE;
                end
              end else if (state == REG_PTR) begin
                addr_nxt  = rx_byte;
                state_nxt = PTR_ACK;
              end else begin
                wdata_nxt = rx_byte;
                wr_nxt    = 1'b1;
                state_nxt = WR_ACK;
              end
            end
          end
        end
        // First SCL fall starts the ACK bit, the second one ends it.
        DEV_ACK, PTR_ACK, WR_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt = 1'b0;
              if (state == DEV_ACK && rw) begin
                state_nxt    = RD_DATA;
                rd_nxt       = 1'b1;
                rd_phase_nxt = 2'd0;
                bit_cnt_nxt  = '0;
              end else if (state == DEV_ACK) begin
                state_nxt = REG_PTR;
              end else begin
                state_nxt = WR_DATA;
              end
            end
          end
        end
        RD_DATA: begin
          case (rd_phase)
            // reg_rd is high this clk, so reg_rdata is valid now.
            2'd0: begin
              tx_nxt       = rbus.reg_rdata;
              rd_phase_nxt = 2'd1;
            end
            2'd1: begin
              addr_nxt     = addr_q + 8'd1;
              sda_oe_nxt   = ~tx_shift[7];
              rd_phase_nxt = 2'd2;
            end
            default: begin
              if (scl_fall) begin
                if (bit_cnt == 4'd7) begin
                  sda_oe_nxt  = 1'b0;
                  bit_cnt_nxt = '0;
                  state_nxt   = RD_MACK;
                end else begin
                  tx_nxt      = {tx_shift[6:0], 1'b0};
                  sda_oe_nxt  = ~tx_shift[6];
                  bit_cnt_nxt = bit_cnt + 4'd1;
                end
              end
            end
          endcase
        end
        // bit_cnt==1 marks an ACK seen on the 9th rise.
        RD_MACK: begin
          if (scl_rise) begin
            if (sda_s) state_nxt = IGNORE;
            else       bit_cnt_nxt = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            state_nxt    = RD_DATA;
            rd_nxt       = 1'b1;
            rd_phase_nxt = 2'd0;
            bit_cnt_nxt  = '0;
          end
        end
        IGNORE:  sda_oe_nxt = 1'b0;
        default: ;
      endcase
    end
  end

  assign rbus.reg_addr  = addr_q;
  assign rbus.reg_wdata = wdata_q;
  assign rbus.reg_wr    = wr_q;
  assign rbus.reg_rd    = rd_q;

endmodule

// File: tb/tb_i2c_reg_bridge.sv
module tb_i2c_reg_bridge;
  localparam int Q = 80;

  logic clk, rst, scl, sda_m;
  logic sda_oe, busy;
  wire  sda_line;

  i2c_reg_bridge_if rbus();

  i2c_reg_bridge #(.SLAVE_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_in (scl),
    .sda_in (sda_line),
    .sda_oe (sda_oe),
    .busy   (busy),
    .rbus   (rbus)
  );

  assign sda_line = sda_m & ~sda_oe;

  logic [7:0]  rf_mem  [256];
  logic [7:0]  ref_mem [256];
  logic [7:0]  m_ptr;
  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];
  logic        oe_seen;
  int          n_chk, n_pass;

  assign rbus.reg_rdata = rf_mem[rbus.reg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    if (a == 8'h00) return 8'hA7;
    if (a == 8'h01) return 8'h01;
    return a * 8'd29 + 8'd3;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endfunction

  // Monitor: register file emulation plus scoreboard pop on every strobe.
  initial begin
    logic [15:0] e;
    for (int i = 0; i < 256; i++) rf_mem[i] = init_val(8'(i));
    forever begin
      @(negedge clk);
      if (sda_oe) oe_seen = 1'b1;
      if (rbus.reg_wr && rbus.reg_rd) begin
        n_chk++;
        $display("FAIL strobe_overlap: reg_wr and reg_rd both high at addr 0x%02h", rbus.reg_addr);
      end
      if (rbus.reg_wr) begin
        rf_mem[rbus.reg_addr] = rbus.reg_wdata;
        if (wr_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_wr: addr 0x%02h data 0x%02h, expected no write", rbus.reg_addr, rbus.reg_wdata);
        end else begin
          e = wr_q.pop_front();
          chk("wr_addr", 32'(rbus.reg_addr), 32'(e[15:8]));
          chk("wr_data", 32'(rbus.reg_wdata), 32'(e[7:0]));
        end
      end
      if (rbus.reg_rd) begin
        if (rd_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_rd: addr 0x%02h, expected no read", rbus.reg_addr);
        end else begin
          chk("rd_addr", 32'(rbus.reg_addr), 32'(rd_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic i2c_start();
    #Q sda_m = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m = 1'b0;
    #Q scl = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q sda_m = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m = 1'b1;
    #Q;
  endtask

  task automatic i2c_bit(input logic b, output logic s);
    #Q sda_m = b;
    #Q scl = 1'b1;
    #Q s = sda_line;
    #Q scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      b[i] = s;
    end
    i2c_bit(nack, s);
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  task automatic wr_txn(input logic [6:0] dev, input logic [7:0] ptr,
                        input logic [7:0] data[$], input string tag);
    logic ack, match;
    match   = (dev == 7'h42);
    oe_seen = 1'b0;
    i2c_start();
    send_byte({dev, 1'b0}, ack);
    chk({tag, "_dev_ack"}, 32'(ack), 32'(match));
    send_byte(ptr, ack);
    chk({tag, "_ptr_ack"}, 32'(ack), 32'(match));
    if (match) m_ptr = ptr;
    foreach (data[i]) begin
      if (match) begin
        wr_q.push_back({m_ptr, data[i]});
        ref_mem[m_ptr] = data[i];
        m_ptr++;
      end
      send_byte(data[i], ack);
      chk({tag, "_data_ack"}, 32'(ack), 32'(match));
    end
    chk({tag, "_busy_during"}, 32'(busy), 32'(match));
    i2c_stop();
    settle();
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_sda_oe_after"}, 32'(sda_oe), 32'd0);
    chk({tag, "_reg_addr"}, 32'(rbus.reg_addr), 32'(m_ptr));
    if (!match) chk({tag, "_no_sda_drive"}, 32'(oe_seen), 32'd0);
  endtask

  task automatic rd_txn(input logic [7:0] ptr, input int n, input string tag);
    logic ack;
    logic [7:0] got, exp;
    i2c_start();
    send_byte(8'h84, ack);
    chk({tag, "_dev_ack"}, 32'(ack), 32'd1);
    send_byte(ptr, ack);
    chk({tag, "_ptr_ack"}, 32'(ack), 32'd1);
    m_ptr = ptr;
    i2c_start();
    send_byte(8'h85, ack);
    chk({tag, "_rdev_ack"}, 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      exp = ref_mem[m_ptr];
      rd_q.push_back(m_ptr);
      m_ptr++;
      recv_byte(i == n - 1, got);
      chk({tag, "_rdata"}, 32'(got), 32'(exp));
    end
    #Q;
    chk({tag, "_released_after_nack"}, 32'(sda_oe), 32'd0);
    i2c_stop();
    settle();
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_reg_addr"}, 32'(rbus.reg_addr), 32'(m_ptr));
  endtask

  initial begin
    logic [7:0] dq [$];
    logic [6:0] dev;
    logic       ack, bs;
    int         op, n;

    n_chk = 0;
    n_pass = 0;
    oe_seen = 1'b0;
    m_ptr = 8'h00;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    rst = 1'b1;
    scl = 1'b1;
    sda_m = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_reg_addr", 32'(rbus.reg_addr), 32'd0);
    chk("rst_reg_wdata", 32'(rbus.reg_wdata), 32'd0);
    chk("rst_strobes", 32'({rbus.reg_wr, rbus.reg_rd}), 32'd0);
    rst = 1'b0;
    settle();

    dq = {8'h5A};             wr_txn(7'h42, 8'h20, dq, "wr1");
    dq = {8'h11, 8'h22};      wr_txn(7'h42, 8'h05, dq, "wr2");
    rd_txn(8'h00, 2, "rd2");
    dq = {8'h5A};             wr_txn(7'h48, 8'h20, dq, "badaddr");
    dq = {8'h33, 8'h44};      wr_txn(7'h42, 8'hFF, dq, "wrap");

    // Partial data byte followed by STOP: pointer loaded, no write.
    i2c_start();
    send_byte(8'h84, ack);
    chk("part_dev_ack", 32'(ack), 32'd1);
    send_byte(8'h20, ack);
    chk("part_ptr_ack", 32'(ack), 32'd1);
    m_ptr = 8'h20;
    for (int i = 0; i < 4; i++) i2c_bit(1'b1, bs);
    i2c_stop();
    settle();
    chk("part_busy", 32'(busy), 32'd0);
    chk("part_reg_addr", 32'(rbus.reg_addr), 32'(m_ptr));

    for (int it = 0; it < 14; it++) begin
      op = int'($urandom_range(0, 2));
      n  = int'($urandom_range(1, 3));
      dq = {};
      for (int k = 0; k < n; k++) dq.push_back(8'($urandom));
      if (op == 0) begin
        wr_txn(7'h42, 8'($urandom), dq, "rnd_wr");
      end else if (op == 1) begin
        rd_txn(8'($urandom), n, "rnd_rd");
      end else begin
        dev = 7'($urandom_range(0, 127));
        if (dev == 7'h42) dev = 7'h43;
        wr_txn(dev, 8'($urandom), dq, "rnd_bad");
      end
    end

    // Reset while the bridge is driving a 0 bit of read data.
    dq = {8'h3C};             wr_txn(7'h42, 8'h80, dq, "pre_rst");
    i2c_start();
    send_byte(8'h84, ack);
    send_byte(8'h80, ack);
    i2c_start();
    rd_q.push_back(8'h80);
    send_byte(8'h85, ack);
    chk("midrd_dev_ack", 32'(ack), 32'd1);
    #Q;
    chk("midrd_driving", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrd_rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("midrd_rst_busy", 32'(busy), 32'd0);
    chk("midrd_rst_reg_addr", 32'(rbus.reg_addr), 32'd0);
    chk("midrd_rst_reg_wdata", 32'(rbus.reg_wdata), 32'd0);
    chk("midrd_rst_strobes", 32'({rbus.reg_wr, rbus.reg_rd}), 32'd0);
    m_ptr = 8'h00;
    sda_m = 1'b1;
    #Q scl = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    settle();
    dq = {8'h77};             wr_txn(7'h42, 8'h10, dq, "post_rst");

    settle();
    chk("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    chk("rd_queue_empty", 32'(rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
